// File: rtl/fixed_adder_arbiter.sv
// rtl/fixed_adder_arbiter.sv - round-robin arbiter sharing one 16-bit saturating adder
// Optional result saturation flag enabled by defining ADDER_ARB_SAT_FLAG_EN.
module fixed_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [15:0]             res_sum,
`ifdef ADDER_ARB_SAT_FLAG_EN
  output logic [ID_W-1:0]         res_id,
  output logic                    res_sat
`else
  output logic [ID_W-1:0]         res_id
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_next;
  logic [ID_W-1:0] grant_id, hi_id, lo_id;
  logic            hi_found, lo_found;
  logic            can_load, xfer;
  logic [15:0]     a_sel, b_sel, raw_sum, sat_sum;
  logic            pos_ovf, neg_ovf;

  // Downward scan leaves the lowest valid index at or above ptr (hi) and the
  // lowest valid index overall (lo); lo is the wrapped choice.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j]) begin
        lo_found = 1'b1;
        lo_id    = ID_W'(j);
        if (j >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(j);
        end
      end
    end
  end

  assign grant_id = hi_found ? hi_id : lo_id;
  assign can_load = !rst && ((state_q == EMPTY) || res_ready);
  assign xfer     = lo_found && can_load;
  assign req_ready = xfer ? (NUM_REQ'(1) << grant_id) : '0;
  assign ptr_next  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_id == ID_W'(j)) begin
        a_sel = req_a[16*j +: 16];
        b_sel = req_b[16*j +: 16];
      end
    end
  end

  assign raw_sum = a_sel + b_sel;
  assign pos_ovf = !a_sel[15] && !b_sel[15] &&  raw_sum[15];
  assign neg_ovf =  a_sel[15] &&  b_sel[15] && !raw_sum[15];
  assign sat_sum = pos_ovf ? 16'h7FFF : (neg_ovf ? 16'h8000 : raw_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (xfer)
      state_d = FULL;
    else if ((state_q == FULL) && res_ready)
      state_d = EMPTY;
  end

  assign res_valid = (state_q == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      res_sum <= '0;
      res_id  <= '0;
    end else if (xfer) begin
      ptr_q   <= ptr_next;
      res_sum <= sat_sum;
      res_id  <= grant_id;
    end
  end

`ifdef ADDER_ARB_SAT_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       res_sat <= 1'b0;
    else if (xfer) res_sat <= pos_ovf || neg_ovf;
  end
`endif

endmodule
